instruction_memory_responder: RTL and testbench

Backing-store responder that answers instruction-cache miss requests.
- Holds a 256 x 16 instruction memory.
- Captures a requested address, waits a programmable access latency, then returns the instruction with a one-cycle valid strobe.
- Sits between the instruction cache's backing-store port and the program loader's write port.

---
 rtl/instruction_memory_responder_pkg.sv | 14 +
 rtl/imem_array.sv | 30 +++
 rtl/instruction_memory_responder.sv | 84 ++++++++
 tb/tb_instruction_memory_responder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/instruction_memory_responder_pkg.sv
// Shared types and default widths for the instruction backing-store path
// (also used by the instruction cache and fetch unit).
package instruction_memory_responder_pkg;

  localparam int IMEM_ADDR_W = 8;
  localparam int IMEM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_e;

endpackage

// File: rtl/imem_array.sv
// Synchronous single-write / single-read instruction RAM. A read and a write
// to the same address on one edge return the old contents.
module imem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Contents survive reset; the loader repopulates them.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port holds its last value when not enabled.
  always_ff @(posedge clk) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instruction_memory_responder.sv
// Backing-store responder for instruction-cache misses: captures a request,
// waits LATENCY cycles, then returns mem[addr] with a one-cycle valid strobe.
module instruction_memory_responder
  import instruction_memory_responder_pkg::*;
#(
  parameter int ADDR_W  = IMEM_ADDR_W,
  parameter int DATA_W  = IMEM_DATA_W,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              backing_read_enable,
  input  logic [ADDR_W-1:0] backing_addr,
  output logic [DATA_W-1:0] backing_data,
  output logic              backing_valid,
  output logic              busy,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [CNT_W-1:0]  req_count
);

  imem_state_e       state, state_n;
  logic [3:0]        wait_cnt, wait_cnt_n;
  logic [ADDR_W-1:0] cap_addr, cap_addr_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      cap_addr      <= '0;
      backing_valid <= 1'b0;
      req_count     <= '0;
    end else begin
      state         <= state_n;
      wait_cnt      <= wait_cnt_n;
      cap_addr      <= cap_addr_n;
      backing_valid <= (state == RESP);
      if (state == RESP) req_count <= req_count + 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    cap_addr_n = cap_addr;
    case (state)
      IDLE: begin
        if (backing_read_enable) begin
          cap_addr_n = backing_addr;
          wait_cnt_n = 4'(LATENCY);
          state_n    = (LATENCY > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        // Request inputs are ignored here; only the countdown advances.
        wait_cnt_n = wait_cnt - 4'd1;
        if (wait_cnt <= 4'd1) state_n = RESP;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // The RESP-cycle edge registers the read, so a program write on that same
  // edge is not seen by this response.
  imem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (prog_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (state == RESP),
    .raddr (cap_addr),
    .rdata (backing_data)
  );

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Bench for instruction_memory_responder: three instances (LATENCY 2, 0 and
// 1 with a 4-bit counter) checked against a timing/memory reference model.
module tb_instruction_memory_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        re    [3];
  logic [7:0]  addr  [3];
  logic        pwe   [3];
  logic [7:0]  paddr [3];
  logic [15:0] pdata [3];
  logic [15:0] bdata [3];
  logic        bvalid[3];
  logic        busy  [3];
  logic [15:0] cnt0, cnt1;
  logic [3:0]  cnt2;

  logic [15:0] mm [3][256];
  int          cnt_model [3];
  int          total  = 0;
  int          passed = 0;
  int          fails  = 0;

  always #5 clk = ~clk;

  instruction_memory_responder #(.LATENCY(2), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .backing_read_enable(re[0]), .backing_addr(addr[0]),
    .backing_data(bdata[0]), .backing_valid(bvalid[0]), .busy(busy[0]),
    .prog_we(pwe[0]), .prog_addr(paddr[0]), .prog_data(pdata[0]), .req_count(cnt0));

  instruction_memory_responder #(.LATENCY(0), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .backing_read_enable(re[1]), .backing_addr(addr[1]),
    .backing_data(bdata[1]), .backing_valid(bvalid[1]), .busy(busy[1]),
    .prog_we(pwe[1]), .prog_addr(paddr[1]), .prog_data(pdata[1]), .req_count(cnt1));

  instruction_memory_responder #(.LATENCY(1), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .backing_read_enable(re[2]), .backing_addr(addr[2]),
    .backing_data(bdata[2]), .backing_valid(bvalid[2]), .busy(busy[2]),
    .prog_we(pwe[2]), .prog_addr(paddr[2]), .prog_data(pdata[2]), .req_count(cnt2));

  function automatic int lat(input int d);
    case (d)
      0:       return 2;
      1:       return 0;
      default: return 1;
    endcase
  endfunction

  function automatic int cnt_mask(input int d);
    return (d == 2) ? 16'h000F : 16'hFFFF;
  endfunction

  function automatic logic [15:0] get_cnt(input int d);
    case (d)
      0:       return cnt0;
      1:       return cnt1;
      default: return {12'd0, cnt2};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int d, input logic [7:0] a, input logic [15:0] v);
    pwe[d] = 1'b1; paddr[d] = a; pdata[d] = v;
    @(negedge clk);
    pwe[d] = 1'b0;
    mm[d][a] = v;
  endtask

  // One request pulse; optional program write to the same address driven at
  // negedge wr_k after the accept edge (lands on edge accept+wr_k). The read
  // happens on edge accept+L+1, so only writes landing earlier are seen.
  task automatic do_req(input int d, input logic [7:0] a, input int wr_k, input logic [15:0] wv);
    int L;
    logic [15:0] exp;
    L   = lat(d);
    exp = (wr_k != 0 && wr_k < L + 1) ? wv : mm[d][a];
    if (wr_k != 0) mm[d][a] = wv;
    re[d] = 1'b1; addr[d] = a;
    for (int k = 1; k <= L + 3; k++) begin
      @(negedge clk);
      re[d] = 1'b0; addr[d] = 8'($urandom); pwe[d] = 1'b0;
      check($sformatf("d%0d a%0h valid k%0d", d, a, k), bvalid[d], (k == L + 2));
      check($sformatf("d%0d a%0h busy k%0d", d, a, k), busy[d], (k <= L + 1));
      if (k == L + 2) begin
        cnt_model[d] = (cnt_model[d] + 1) & cnt_mask(d);
        check($sformatf("d%0d a%0h data", d, a), bdata[d], exp);
        check($sformatf("d%0d count", d), get_cnt(d), cnt_model[d]);
      end
      if (k == L + 3) check($sformatf("d%0d a%0h data hold", d, a), bdata[d], exp);
      if (k == wr_k) begin
        pwe[d] = 1'b1; paddr[d] = a; pdata[d] = wv;
      end
    end
  endtask

  // Request held high: one response every L+2 cycles, never two in a row.
  task automatic hold(input int d, input logic [7:0] a, input int nresp);
    int P;
    P = lat(d) + 2;
    re[d] = 1'b1; addr[d] = a;
    for (int k = 1; k <= nresp * P + 1; k++) begin
      @(negedge clk);
      check($sformatf("d%0d hold valid k%0d", d, k), bvalid[d], (k % P == 0) && (k <= nresp * P));
      if (k % P == 0 && k <= nresp * P) begin
        cnt_model[d] = (cnt_model[d] + 1) & cnt_mask(d);
        check($sformatf("d%0d hold data k%0d", d, k), bdata[d], mm[d][a]);
        check($sformatf("d%0d hold count k%0d", d, k), get_cnt(d), cnt_model[d]);
      end
      if (k == nresp * P) re[d] = 1'b0;
    end
    check($sformatf("d%0d hold idle", d), busy[d], 1'b0);
  endtask

  initial begin
    logic [7:0]  a;
    logic [15:0] v;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      re[d] = 1'b0; addr[d] = '0; pwe[d] = 1'b0; paddr[d] = '0; pdata[d] = '0;
      cnt_model[d] = 0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("d%0d reset valid", d), bvalid[d], 1'b0);
      check($sformatf("d%0d reset busy", d), busy[d], 1'b0);
      check($sformatf("d%0d reset data", d), bdata[d], 16'h0000);
      check($sformatf("d%0d reset count", d), get_cnt(d), 16'h0000);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Basic read, LATENCY=2
    load(0, 8'h15, 16'hA5C3);
    do_req(0, 8'h15, 0, 16'h0);

    // Continuous request
    load(0, 8'h07, 16'($urandom));
    hold(0, 8'h07, 4);

    // Write during WAIT is visible; write on the read edge is not
    load(0, 8'h20, 16'h1111);
    do_req(0, 8'h20, 1, 16'h2222);
    load(0, 8'h20, 16'h1111);
    do_req(0, 8'h20, 3, 16'h2222);
    do_req(0, 8'h20, 0, 16'h0);

    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom); v = 16'($urandom);
      load(0, a, v);
      do_req(0, a, int'($urandom_range(0, 3)), 16'($urandom));
    end

    // Reset during WAIT, with the request still asserted through reset
    load(0, 8'h33, 16'h5A5A);
    re[0] = 1'b1; addr[0] = 8'h33;
    @(negedge clk);
    check("rst mid busy before", busy[0], 1'b1);
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) cnt_model[d] = 0;
    repeat (2) begin
      @(negedge clk);
      check("rst mid busy", busy[0], 1'b0);
      check("rst mid valid", bvalid[0], 1'b0);
      check("rst mid count", get_cnt(0), 16'h0000);
    end
    rst_n = 1'b1; re[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("post rst valid k%0d", k), bvalid[0], 1'b0);
      check($sformatf("post rst busy k%0d", k), busy[0], 1'b0);
    end
    do_req(0, 8'h33, 0, 16'h0);

    // LATENCY=0
    load(1, 8'hFF, 16'hBEEF);
    do_req(1, 8'hFF, 0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom); v = 16'($urandom);
      load(1, a, v);
      do_req(1, a, int'($urandom_range(0, 1)), 16'($urandom));
    end

    // 4-bit counter wraps after 16 responses
    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom); v = 16'($urandom);
      load(2, a, v);
      do_req(2, a, int'($urandom_range(0, 2)), 16'($urandom));
    end
    check("wrap count zero", get_cnt(2), 16'h0000);
    load(2, 8'h00, 16'h1234);
    do_req(2, 8'h00, 0, 16'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
